// File: rtl/s10_acp_txn_limiter.sv
// AXI4 128-bit pass-through limiter in front of the ACP bridge s0 port. It caps
// outstanding reads and writes, holds W until its AW is accepted, and supports a drain handshake.
module s10_acp_txn_limiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int MAX_RD     = 8,
  parameter int MAX_WR     = 8,
  parameter int CNT_W      = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  // upstream read address
  input  logic [ADDR_WIDTH-1:0] axs_s0_araddr,
  input  logic [1:0]            axs_s0_arburst,
  input  logic [3:0]            axs_s0_arcache,
  input  logic [3:0]            axs_s0_arid,
  input  logic [7:0]            axs_s0_arlen,
  input  logic                  axs_s0_arlock,
  input  logic [2:0]            axs_s0_arprot,
  input  logic [2:0]            axs_s0_arsize,
  input  logic                  axs_s0_arvalid,
  output logic                  axs_s0_arready,
  // upstream write address
  input  logic [ADDR_WIDTH-1:0] axs_s0_awaddr,
  input  logic [1:0]            axs_s0_awburst,
  input  logic [3:0]            axs_s0_awcache,
  input  logic [3:0]            axs_s0_awid,
  input  logic [7:0]            axs_s0_awlen,
  input  logic                  axs_s0_awlock,
  input  logic [2:0]            axs_s0_awprot,
  input  logic [2:0]            axs_s0_awsize,
  input  logic                  axs_s0_awvalid,
  output logic                  axs_s0_awready,
  // upstream write data / response / read data
  input  logic [127:0]          axs_s0_wdata,
  input  logic [15:0]           axs_s0_wstrb,
  input  logic                  axs_s0_wlast,
  input  logic                  axs_s0_wvalid,
  output logic                  axs_s0_wready,
  output logic [3:0]            axs_s0_bid,
  output logic [1:0]            axs_s0_bresp,
  output logic                  axs_s0_bvalid,
  input  logic                  axs_s0_bready,
  output logic [127:0]          axs_s0_rdata,
  output logic [3:0]            axs_s0_rid,
  output logic [1:0]            axs_s0_rresp,
  output logic                  axs_s0_rlast,
  output logic                  axs_s0_rvalid,
  input  logic                  axs_s0_rready,
  // downstream toward ACP bridge s0
  output logic [ADDR_WIDTH-1:0] axm_m0_araddr,
  output logic [1:0]            axm_m0_arburst,
  output logic [3:0]            axm_m0_arcache,
  output logic [3:0]            axm_m0_arid,
  output logic [7:0]            axm_m0_arlen,
  output logic                  axm_m0_arlock,
  output logic [2:0]            axm_m0_arprot,
  output logic [2:0]            axm_m0_arsize,
  output logic                  axm_m0_arvalid,
  input  logic                  axm_m0_arready,
  output logic [ADDR_WIDTH-1:0] axm_m0_awaddr,
  output logic [1:0]            axm_m0_awburst,
  output logic [3:0]            axm_m0_awcache,
  output logic [3:0]            axm_m0_awid,
  output logic [7:0]            axm_m0_awlen,
  output logic                  axm_m0_awlock,
  output logic [2:0]            axm_m0_awprot,
  output logic [2:0]            axm_m0_awsize,
  output logic                  axm_m0_awvalid,
  input  logic                  axm_m0_awready,
  output logic [127:0]          axm_m0_wdata,
  output logic [15:0]           axm_m0_wstrb,
  output logic                  axm_m0_wlast,
  output logic                  axm_m0_wvalid,
  input  logic                  axm_m0_wready,
  input  logic [3:0]            axm_m0_bid,
  input  logic [1:0]            axm_m0_bresp,
  input  logic                  axm_m0_bvalid,
  output logic                  axm_m0_bready,
  input  logic [127:0]          axm_m0_rdata,
  input  logic [3:0]            axm_m0_rid,
  input  logic [1:0]            axm_m0_rresp,
  input  logic                  axm_m0_rlast,
  input  logic                  axm_m0_rvalid,
  output logic                  axm_m0_rready,
  // drain / status
  input  logic                  drain_req,
  output logic                  drain_done,
  output logic [CNT_W-1:0]      rd_outstanding,
  output logic [CNT_W-1:0]      wr_outstanding,
  output logic                  err_underflow
);

  localparam logic [CNT_W-1:0] MAX_RD_C = CNT_W'(MAX_RD);
  localparam logic [CNT_W-1:0] MAX_WR_C = CNT_W'(MAX_WR);

  logic [CNT_W-1:0] rd_cnt_q, rd_cnt_d;
  logic [CNT_W-1:0] wr_cnt_q, wr_cnt_d;
  logic [CNT_W-1:0] wpend_q, wpend_d;
  logic             err_q, err_d;
  logic             drain_done_q, drain_done_d;

  logic ar_ok, aw_ok, w_ok;
  logic ar_hs, aw_hs, w_last_hs, r_last_hs, b_hs;

  // Payload is wired straight through; only valid/ready are gated.
  assign axm_m0_araddr  = axs_s0_araddr;
  assign axm_m0_arburst = axs_s0_arburst;
  assign axm_m0_arcache = axs_s0_arcache;
  assign axm_m0_arid    = axs_s0_arid;
  assign axm_m0_arlen   = axs_s0_arlen;
  assign axm_m0_arlock  = axs_s0_arlock;
  assign axm_m0_arprot  = axs_s0_arprot;
  assign axm_m0_arsize  = axs_s0_arsize;
  assign axm_m0_awaddr  = axs_s0_awaddr;
  assign axm_m0_awburst = axs_s0_awburst;
  assign axm_m0_awcache = axs_s0_awcache;
  assign axm_m0_awid    = axs_s0_awid;
  assign axm_m0_awlen   = axs_s0_awlen;
  assign axm_m0_awlock  = axs_s0_awlock;
  assign axm_m0_awprot  = axs_s0_awprot;
  assign axm_m0_awsize  = axs_s0_awsize;
  assign axm_m0_wdata   = axs_s0_wdata;
  assign axm_m0_wstrb   = axs_s0_wstrb;
  assign axm_m0_wlast   = axs_s0_wlast;
  assign axs_s0_bid     = axm_m0_bid;
  assign axs_s0_bresp   = axm_m0_bresp;
  assign axs_s0_bvalid  = axm_m0_bvalid;
  assign axm_m0_bready  = axs_s0_bready;
  assign axs_s0_rdata   = axm_m0_rdata;
  assign axs_s0_rid     = axm_m0_rid;
  assign axs_s0_rresp   = axm_m0_rresp;
  assign axs_s0_rlast   = axm_m0_rlast;
  assign axs_s0_rvalid  = axm_m0_rvalid;
  assign axm_m0_rready  = axs_s0_rready;

  // Gates look only at registered counts, so a W beat never bypasses its own AW.
  assign ar_ok = reset_n & ~drain_req & (rd_cnt_q < MAX_RD_C);
  assign aw_ok = reset_n & ~drain_req & (wr_cnt_q < MAX_WR_C);
  assign w_ok  = reset_n & (wpend_q != '0);

  assign axm_m0_arvalid = axs_s0_arvalid & ar_ok;
  assign axs_s0_arready = axm_m0_arready & ar_ok;
  assign axm_m0_awvalid = axs_s0_awvalid & aw_ok;
  assign axs_s0_awready = axm_m0_awready & aw_ok;
  assign axm_m0_wvalid  = axs_s0_wvalid  & w_ok;
  assign axs_s0_wready  = axm_m0_wready  & w_ok;

  assign ar_hs     = axm_m0_arvalid & axm_m0_arready;
  assign aw_hs     = axm_m0_awvalid & axm_m0_awready;
  assign w_last_hs = axm_m0_wvalid  & axm_m0_wready & axs_s0_wlast;
  assign r_last_hs = axm_m0_rvalid  & axs_s0_rready & axm_m0_rlast;
  assign b_hs      = axm_m0_bvalid  & axs_s0_bready;

  function automatic logic [CNT_W-1:0] cnt_step(input logic [CNT_W-1:0] cnt,
                                                 input logic inc, input logic dec,
                                                 input logic [CNT_W-1:0] max);
    cnt_step = cnt;
    if (inc && !dec && cnt != max)       cnt_step = cnt + 1'b1;
    else if (dec && !inc && cnt != '0)   cnt_step = cnt - 1'b1;
  endfunction

  // NOTE: every always_comb output is assigned on all paths so no latch is inferred.
  always_comb begin
    rd_cnt_d     = cnt_step(rd_cnt_q, ar_hs, r_last_hs, MAX_RD_C);
    wr_cnt_d     = cnt_step(wr_cnt_q, aw_hs, b_hs, MAX_WR_C);
    wpend_d      = cnt_step(wpend_q, aw_hs, w_last_hs, MAX_WR_C);
    err_d        = err_q
                 | (r_last_hs & (rd_cnt_q == '0))
                 | (b_hs      & (wr_cnt_q == '0))
                 | (w_last_hs & (wpend_q  == '0));
    drain_done_d = drain_req & (rd_cnt_q == '0) & (wr_cnt_q == '0) & (wpend_q == '0);
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rd_cnt_q     <= '0;
      wr_cnt_q     <= '0;
      wpend_q      <= '0;
      err_q        <= 1'b0;
      drain_done_q <= 1'b0;
    end else begin
      rd_cnt_q     <= rd_cnt_d;
      wr_cnt_q     <= wr_cnt_d;
      wpend_q      <= wpend_d;
      err_q        <= err_d;
      drain_done_q <= drain_done_d;
    end
  end

  assign drain_done     = drain_done_q;
  assign rd_outstanding = rd_cnt_q;
  assign wr_outstanding = wr_cnt_q;
  assign err_underflow  = err_q;

endmodule

// File: tb/tb_s10_acp_txn_limiter.sv
// Self-checking bench for s10_acp_txn_limiter: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a count-based reference model.
module tb_s10_acp_txn_limiter;

  localparam int AW_W   = 32;
  localparam int MAX_RD = 4;
  localparam int MAX_WR = 4;
  localparam int CNT_W  = 4;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  logic [AW_W-1:0] axs_s0_araddr, axs_s0_awaddr;
  logic [1:0]  axs_s0_arburst, axs_s0_awburst;
  logic [3:0]  axs_s0_arcache, axs_s0_arid, axs_s0_awcache, axs_s0_awid;
  logic [7:0]  axs_s0_arlen, axs_s0_awlen;
  logic        axs_s0_arlock, axs_s0_awlock, axs_s0_arvalid, axs_s0_awvalid;
  logic [2:0]  axs_s0_arprot, axs_s0_arsize, axs_s0_awprot, axs_s0_awsize;
  logic [127:0] axs_s0_wdata;
  logic [15:0] axs_s0_wstrb;
  logic        axs_s0_wlast, axs_s0_wvalid, axs_s0_bready, axs_s0_rready;
  logic        axm_m0_arready, axm_m0_awready, axm_m0_wready;
  logic [3:0]  axm_m0_bid, axm_m0_rid;
  logic [1:0]  axm_m0_bresp, axm_m0_rresp;
  logic        axm_m0_bvalid, axm_m0_rlast, axm_m0_rvalid;
  logic [127:0] axm_m0_rdata;
  logic        drain_req;

  wire         axs_s0_arready, axs_s0_awready, axs_s0_wready;
  wire [3:0]   axs_s0_bid, axs_s0_rid;
  wire [1:0]   axs_s0_bresp, axs_s0_rresp;
  wire         axs_s0_bvalid, axs_s0_rlast, axs_s0_rvalid;
  wire [127:0] axs_s0_rdata;
  wire [AW_W-1:0] axm_m0_araddr, axm_m0_awaddr;
  wire [1:0]   axm_m0_arburst, axm_m0_awburst;
  wire [3:0]   axm_m0_arcache, axm_m0_arid, axm_m0_awcache, axm_m0_awid;
  wire [7:0]   axm_m0_arlen, axm_m0_awlen;
  wire         axm_m0_arlock, axm_m0_awlock, axm_m0_arvalid, axm_m0_awvalid;
  wire [2:0]   axm_m0_arprot, axm_m0_arsize, axm_m0_awprot, axm_m0_awsize;
  wire [127:0] axm_m0_wdata;
  wire [15:0]  axm_m0_wstrb;
  wire         axm_m0_wlast, axm_m0_wvalid, axm_m0_bready, axm_m0_rready;
  wire         drain_done, err_underflow;
  wire [CNT_W-1:0] rd_outstanding, wr_outstanding;

  s10_acp_txn_limiter #(.ADDR_WIDTH(AW_W), .MAX_RD(MAX_RD), .MAX_WR(MAX_WR), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset_n(reset_n),
    .axs_s0_araddr(axs_s0_araddr), .axs_s0_arburst(axs_s0_arburst), .axs_s0_arcache(axs_s0_arcache),
    .axs_s0_arid(axs_s0_arid), .axs_s0_arlen(axs_s0_arlen), .axs_s0_arlock(axs_s0_arlock),
    .axs_s0_arprot(axs_s0_arprot), .axs_s0_arsize(axs_s0_arsize), .axs_s0_arvalid(axs_s0_arvalid),
    .axs_s0_arready(axs_s0_arready),
    .axs_s0_awaddr(axs_s0_awaddr), .axs_s0_awburst(axs_s0_awburst), .axs_s0_awcache(axs_s0_awcache),
    .axs_s0_awid(axs_s0_awid), .axs_s0_awlen(axs_s0_awlen), .axs_s0_awlock(axs_s0_awlock),
    .axs_s0_awprot(axs_s0_awprot), .axs_s0_awsize(axs_s0_awsize), .axs_s0_awvalid(axs_s0_awvalid),
    .axs_s0_awready(axs_s0_awready),
    .axs_s0_wdata(axs_s0_wdata), .axs_s0_wstrb(axs_s0_wstrb), .axs_s0_wlast(axs_s0_wlast),
    .axs_s0_wvalid(axs_s0_wvalid), .axs_s0_wready(axs_s0_wready),
    .axs_s0_bid(axs_s0_bid), .axs_s0_bresp(axs_s0_bresp), .axs_s0_bvalid(axs_s0_bvalid),
    .axs_s0_bready(axs_s0_bready),
    .axs_s0_rdata(axs_s0_rdata), .axs_s0_rid(axs_s0_rid), .axs_s0_rresp(axs_s0_rresp),
    .axs_s0_rlast(axs_s0_rlast), .axs_s0_rvalid(axs_s0_rvalid), .axs_s0_rready(axs_s0_rready),
    .axm_m0_araddr(axm_m0_araddr), .axm_m0_arburst(axm_m0_arburst), .axm_m0_arcache(axm_m0_arcache),
    .axm_m0_arid(axm_m0_arid), .axm_m0_arlen(axm_m0_arlen), .axm_m0_arlock(axm_m0_arlock),
    .axm_m0_arprot(axm_m0_arprot), .axm_m0_arsize(axm_m0_arsize), .axm_m0_arvalid(axm_m0_arvalid),
    .axm_m0_arready(axm_m0_arready),
    .axm_m0_awaddr(axm_m0_awaddr), .axm_m0_awburst(axm_m0_awburst), .axm_m0_awcache(axm_m0_awcache),
    .axm_m0_awid(axm_m0_awid), .axm_m0_awlen(axm_m0_awlen), .axm_m0_awlock(axm_m0_awlock),
    .axm_m0_awprot(axm_m0_awprot), .axm_m0_awsize(axm_m0_awsize), .axm_m0_awvalid(axm_m0_awvalid),
    .axm_m0_awready(axm_m0_awready),
    .axm_m0_wdata(axm_m0_wdata), .axm_m0_wstrb(axm_m0_wstrb), .axm_m0_wlast(axm_m0_wlast),
    .axm_m0_wvalid(axm_m0_wvalid), .axm_m0_wready(axm_m0_wready),
    .axm_m0_bid(axm_m0_bid), .axm_m0_bresp(axm_m0_bresp), .axm_m0_bvalid(axm_m0_bvalid),
    .axm_m0_bready(axm_m0_bready),
    .axm_m0_rdata(axm_m0_rdata), .axm_m0_rid(axm_m0_rid), .axm_m0_rresp(axm_m0_rresp),
    .axm_m0_rlast(axm_m0_rlast), .axm_m0_rvalid(axm_m0_rvalid), .axm_m0_rready(axm_m0_rready),
    .drain_req(drain_req), .drain_done(drain_done),
    .rd_outstanding(rd_outstanding), .wr_outstanding(wr_outstanding),
    .err_underflow(err_underflow)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: plain integer transaction counts, floored at zero.
  int m_rd = 0, m_wr = 0, m_wp = 0;
  bit m_err = 0, m_dd = 0;

  function automatic int floor0(input int v);
    return (v < 0) ? 0 : v;
  endfunction

  always @(posedge clk) begin : model
    bit ar_acc, aw_acc, w_done, r_done, b_done;
    if (!reset_n) begin
      m_rd <= 0; m_wr <= 0; m_wp <= 0; m_err <= 0; m_dd <= 0;
    end else begin
      ar_acc = axs_s0_arvalid && axm_m0_arready && !drain_req && (m_rd < MAX_RD);
      aw_acc = axs_s0_awvalid && axm_m0_awready && !drain_req && (m_wr < MAX_WR);
      w_done = axs_s0_wvalid && axm_m0_wready && axs_s0_wlast && (m_wp > 0);
      r_done = axm_m0_rvalid && axs_s0_rready && axm_m0_rlast;
      b_done = axm_m0_bvalid && axs_s0_bready;
      m_dd  <= drain_req && m_rd == 0 && m_wr == 0 && m_wp == 0;
      if ((r_done && m_rd == 0) || (b_done && m_wr == 0)) m_err <= 1;
      m_rd <= floor0(m_rd + int'(ar_acc) - int'(r_done));
      m_wr <= floor0(m_wr + int'(aw_acc) - int'(b_done));
      m_wp <= floor0(m_wp + int'(aw_acc) - int'(w_done));
    end
  end

  bit cmp_en = 1;
  always @(negedge clk) begin
    bit ar_ok, aw_ok, w_ok;
    if (cmp_en) begin
      ar_ok = reset_n && !drain_req && (m_rd < MAX_RD);
      aw_ok = reset_n && !drain_req && (m_wr < MAX_WR);
      w_ok  = reset_n && (m_wp > 0);
      check("m_arvalid", axm_m0_arvalid, axs_s0_arvalid && ar_ok);
      check("s_arready", axs_s0_arready, axm_m0_arready && ar_ok);
      check("m_awvalid", axm_m0_awvalid, axs_s0_awvalid && aw_ok);
      check("s_awready", axs_s0_awready, axm_m0_awready && aw_ok);
      check("m_wvalid",  axm_m0_wvalid,  axs_s0_wvalid && w_ok);
      check("s_wready",  axs_s0_wready,  axm_m0_wready && w_ok);
      check("r_hs_pass", {axs_s0_rvalid, axm_m0_rready}, {axm_m0_rvalid, axs_s0_rready});
      check("b_pass", {axs_s0_bvalid, axm_m0_bready, axs_s0_bid, axs_s0_bresp},
                      {axm_m0_bvalid, axs_s0_bready, axm_m0_bid, axm_m0_bresp});
      check("ar_payload", {axm_m0_araddr, axm_m0_arburst, axm_m0_arcache, axm_m0_arid,
                           axm_m0_arlen, axm_m0_arlock, axm_m0_arprot, axm_m0_arsize},
                          {axs_s0_araddr, axs_s0_arburst, axs_s0_arcache, axs_s0_arid,
                           axs_s0_arlen, axs_s0_arlock, axs_s0_arprot, axs_s0_arsize});
      check("aw_payload", {axm_m0_awaddr, axm_m0_awburst, axm_m0_awcache, axm_m0_awid,
                           axm_m0_awlen, axm_m0_awlock, axm_m0_awprot, axm_m0_awsize},
                          {axs_s0_awaddr, axs_s0_awburst, axs_s0_awcache, axs_s0_awid,
                           axs_s0_awlen, axs_s0_awlock, axs_s0_awprot, axs_s0_awsize});
      check("wdata", axm_m0_wdata, axs_s0_wdata);
      check("w_ctl", {axm_m0_wstrb, axm_m0_wlast}, {axs_s0_wstrb, axs_s0_wlast});
      check("rdata", axs_s0_rdata, axm_m0_rdata);
      check("r_ctl", {axs_s0_rid, axs_s0_rresp, axs_s0_rlast}, {axm_m0_rid, axm_m0_rresp, axm_m0_rlast});
      check("rd_outstanding", rd_outstanding, m_rd);
      check("wr_outstanding", wr_outstanding, m_wr);
      check("err_underflow", err_underflow, m_err);
      check("drain_done", drain_done, m_dd);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic randomize_payload();
    axs_s0_araddr = $urandom; axs_s0_arburst = 2'($urandom); axs_s0_arcache = 4'($urandom);
    axs_s0_arid = 4'($urandom); axs_s0_arlen = 8'($urandom); axs_s0_arlock = 1'($urandom);
    axs_s0_arprot = 3'($urandom); axs_s0_arsize = 3'($urandom);
    axs_s0_awaddr = $urandom; axs_s0_awburst = 2'($urandom); axs_s0_awcache = 4'($urandom);
    axs_s0_awid = 4'($urandom); axs_s0_awlen = 8'($urandom); axs_s0_awlock = 1'($urandom);
    axs_s0_awprot = 3'($urandom); axs_s0_awsize = 3'($urandom);
    axs_s0_wdata = {$urandom, $urandom, $urandom, $urandom}; axs_s0_wstrb = 16'($urandom);
    axm_m0_rdata = {$urandom, $urandom, $urandom, $urandom};
    axm_m0_rid = 4'($urandom); axm_m0_rresp = 2'($urandom);
    axm_m0_bid = 4'($urandom); axm_m0_bresp = 2'($urandom);
  endtask

  initial begin
    int acc;
    logic fifth;
    reset_n = 0; drain_req = 0;
    axs_s0_arvalid = 0; axs_s0_awvalid = 0; axs_s0_wvalid = 0; axs_s0_wlast = 0;
    axs_s0_bready = 0; axs_s0_rready = 0;
    axm_m0_arready = 1; axm_m0_awready = 1; axm_m0_wready = 1;
    axm_m0_bvalid = 0; axm_m0_rvalid = 0; axm_m0_rlast = 0;
    randomize_payload();

    // Reset: gated outputs stay low even with valid/ready presented.
    repeat (2) cyc();
    axs_s0_arvalid = 1; axs_s0_awvalid = 1;
    #1;
    check("rst_arready", axs_s0_arready, 0);
    check("rst_awvalid", axm_m0_awvalid, 0);
    check("rst_rd_out", rd_outstanding, 0);
    check("rst_err", err_underflow, 0);
    axs_s0_arvalid = 0; axs_s0_awvalid = 0;
    reset_n = 1;
    cyc();

    // Single 4-beat read.
    axs_s0_arvalid = 1; axs_s0_arlen = 8'd3;
    #1 check("t1_arvalid_same_cycle", axm_m0_arvalid, 1);
    cyc();
    axs_s0_arvalid = 0;
    #1 check("t1_rd_out_1", rd_outstanding, 1);
    axs_s0_rready = 1;
    for (int i = 0; i < 4; i++) begin
      axm_m0_rvalid = 1; axm_m0_rlast = (i == 3);
      cyc();
    end
    axm_m0_rvalid = 0; axm_m0_rlast = 0;
    #1;
    check("t1_rd_out_0", rd_outstanding, 0);
    check("t1_no_err", err_underflow, 0);

    // Read saturation at MAX_RD = 4 with R stalled.
    axs_s0_arvalid = 1; acc = 0; fifth = 1'bx;
    for (int i = 0; i < 6; i++) begin
      #1;
      if (axs_s0_arready) acc++;
      if (i == 4) fifth = axs_s0_arready;
      cyc();
    end
    check("t2_accepted", acc, 4);
    check("t2_fifth_blocked", fifth, 0);
    axm_m0_rvalid = 1; axm_m0_rlast = 1;
    #1 check("t2_gate_holds_same_cycle", axs_s0_arready, 0);
    cyc();
    axm_m0_rvalid = 0; axm_m0_rlast = 0;
    #1 check("t2_reopen_next_cycle", axs_s0_arready, 1);
    cyc();
    axs_s0_arvalid = 0;
    #1 check("t2_rd_out_4", rd_outstanding, 4);

    // Drop to 2, then simultaneous AR and rlast.
    axm_m0_rvalid = 1; axm_m0_rlast = 1;
    repeat (2) cyc();
    axs_s0_arvalid = 1;
    cyc();
    axs_s0_arvalid = 0;
    #1 check("t3_simul_rd_2", rd_outstanding, 2);
    repeat (2) cyc();
    axm_m0_rvalid = 0; axm_m0_rlast = 0;
    #1 check("t3_rd_out_0", rd_outstanding, 0);

    // AW and first W beat in the same cycle.
    axs_s0_awvalid = 1; axs_s0_wvalid = 1; axs_s0_wlast = 0;
    #1 check("t4_w_waits", axm_m0_wvalid, 0);
    cyc();
    axs_s0_awvalid = 0;
    #1 check("t4_w_open", axm_m0_wvalid, 1);
    cyc();
    axs_s0_wlast = 1;
    cyc();
    axs_s0_wlast = 0;
    #1;
    check("t4_wpend_zero", axm_m0_wvalid, 0);
    check("t4_wr_held", wr_outstanding, 1);
    axs_s0_wvalid = 0;
    cyc();
    axm_m0_bvalid = 1; axs_s0_bready = 1;
    cyc();
    axm_m0_bvalid = 0;
    #1 check("t4_wr_out_0", wr_outstanding, 0);

    // Drain with 3 reads outstanding.
    axs_s0_arvalid = 1;
    repeat (3) cyc();
    drain_req = 1; axs_s0_awvalid = 1;
    #1;
    check("t5_ar_withheld", axm_m0_arvalid, 0);
    check("t5_arready_low", axs_s0_arready, 0);
    check("t5_aw_withheld", axm_m0_awvalid, 0);
    check("t5_rd_out_3", rd_outstanding, 3);
    axm_m0_rvalid = 1; axm_m0_rlast = 1;
    repeat (3) cyc();
    axm_m0_rvalid = 0; axm_m0_rlast = 0;
    cyc();
    check("t5_drain_done", drain_done, 1);
    drain_req = 0; axs_s0_arvalid = 0; axs_s0_awvalid = 0;
    #1 check("t5_dd_still_high", drain_done, 1);
    cyc();
    check("t5_dd_cleared", drain_done, 0);

    // B response with nothing outstanding.
    axm_m0_bvalid = 1; axs_s0_bready = 1;
    #1 check("t6_bvalid_fwd", axs_s0_bvalid, 1);
    cyc();
    axm_m0_bvalid = 0;
    #1;
    check("t6_wr_stays_0", wr_outstanding, 0);
    check("t6_err_set", err_underflow, 1);
    repeat (3) cyc();
    check("t6_err_sticky", err_underflow, 1);
    reset_n = 0;
    cyc();
    reset_n = 1;
    #1 check("t6_err_cleared", err_underflow, 0);
    cyc();

    // Randomized traffic; responses only for transactions the model knows are outstanding.
    for (int n = 0; n < 3000; n++) begin
      randomize_payload();
      reset_n        = !(n >= 1500 && n < 1502);
      if ($urandom_range(0, 24) == 0) drain_req = !drain_req;
      axs_s0_arvalid = 1'($urandom);
      axs_s0_awvalid = 1'($urandom);
      axs_s0_wvalid  = 1'($urandom);
      axs_s0_wlast   = ($urandom_range(0, 2) == 0);
      axm_m0_arready = ($urandom_range(0, 3) != 0);
      axm_m0_awready = ($urandom_range(0, 3) != 0);
      axm_m0_wready  = ($urandom_range(0, 3) != 0);
      axm_m0_rvalid  = (m_rd > 0) && 1'($urandom);
      axm_m0_rlast   = ($urandom_range(0, 2) == 0);
      axs_s0_rready  = ($urandom_range(0, 3) != 0);
      axm_m0_bvalid  = (m_wr > m_wp) && 1'($urandom);
      axs_s0_bready  = ($urandom_range(0, 3) != 0);
      cyc();
    end

    @(negedge clk);
    cmp_en = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/s10_acp_txn_limiter.md
Name: s10_acp_txn_limiter

Overview:
- AXI4 128-bit pass-through stage placed directly upstream of the ACP bridge, on its s0 slave side.
- Caps outstanding reads and writes toward the HPS F2S/ACP path.
- Forwards W beats only after the matching AW has been accepted.
- Provides a drain handshake, so software can quiesce traffic before it changes the bridge's cache/domain/prot attributes.

Parameters:
- ADDR_WIDTH, 32, address width of AR/AW channels.
- MAX_RD, 8, max outstanding read bursts (1..15).
- MAX_WR, 8, max outstanding write bursts, AW accepted until B (1..15).
- CNT_W, 4, counter width; must satisfy 2^CNT_W > max(MAX_RD, MAX_WR).

Ports:
- clk  in  1  single clock for all logic.
- reset_n  in  1  synchronous, active-low reset.
- axs_s0_ar{addr,burst,cache,id,len,lock,prot,size,valid}  in  ADDR_WIDTH/2/4/4/8/1/3/3/1  upstream read address.
- axs_s0_arready  out  1.
- axs_s0_aw{addr,burst,cache,id,len,lock,prot,size,valid}  in  same widths as AR  upstream write address.
- axs_s0_awready  out  1.
- axs_s0_w{data,strb,last,valid}  in  128/16/1/1.
- axs_s0_wready  out  1.
- axs_s0_{bid,bresp,bvalid}  out  4/2/1.
- axs_s0_bready  in  1.
- axs_s0_{rdata,rid,rresp,rlast,rvalid}  out  128/4/2/1/1.
- axs_s0_rready  in  1.
- axm_m0_*  mirror of axs_s0_* with directions reversed; feeds the ACP bridge s0.
- drain_req  in  1  level; while high, no new AR/AW is accepted.
- drain_done  out  1  drain_req high and all counters zero.
- rd_outstanding  out  CNT_W  current read count.
- wr_outstanding  out  CNT_W  current write count.
- err_underflow  out  1  sticky; a response arrived with its counter at 0.

Behaviour:
- Reset (reset_n low at a clk edge):
  - rd_cnt, wr_cnt, wpend_cnt, err_underflow clear to 0.
  - drain_done = 0.
  - All gated valid/ready outputs are 0 during reset and are combinational on state afterwards.
  - Reset mid-burst abandons all tracking; the downstream is reset by the same reset_n.
- Payload fields pass through combinationally with 0 added latency. Only valid/ready are gated. No storage of payload.
- AR gate:
  - ar_ok = !drain_req && rd_cnt < MAX_RD.
  - axm_m0_arvalid = axs_s0_arvalid & ar_ok.
  - axs_s0_arready = axm_m0_arready & ar_ok.
- AW gate: aw_ok = !drain_req && wr_cnt < MAX_WR; same structure as the AR gate.
- W gate:
  - w_ok = wpend_cnt != 0, from the registered count only.
  - No same-cycle AW bypass: a W beat presented alongside its AW waits at least 1 cycle.
  - axm_m0_wvalid = axs_s0_wvalid & w_ok.
  - axs_s0_wready = axm_m0_wready & w_ok.
- R and B channels are pure pass-through and are never gated.
- Counters are updated at the clk edge:
  - rd_cnt: +1 on an m0 AR handshake; -1 on an m0 R handshake with rlast.
  - wr_cnt: +1 on an m0 AW handshake; -1 on an m0 B handshake.
  - wpend_cnt: +1 on an m0 AW handshake; -1 on an m0 W handshake with wlast. Bounded by MAX_WR.
  - Simultaneous increment and decrement on the same counter leaves it unchanged.
- Underflow: a decrement event with the counter already 0 holds the counter at 0 and sets err_underflow. The response is still forwarded. The flag clears only on reset.
- Saturation:
  - A counter equal to its MAX blocks further acceptance; it never exceeds MAX.
  - A same-cycle decrement at MAX does not re-open the gate until the next cycle, because gates use registered counts.
- Drain:
  - drain_req is sampled combinationally into the gates.
  - An AR/AW already presented but not yet accepted is withheld; valid drops. This AXI valid-retraction is accepted for this point-to-point link only.
  - drain_done = drain_req && rd_cnt==0 && wr_cnt==0 && wpend_cnt==0, registered (1-cycle latency).
  - drain_done deasserts the cycle after drain_req falls.
- rd_outstanding and wr_outstanding are the registered counter values.

Test Plan:
- Reset, then a single 4-beat read (arlen=3): arvalid passes same cycle; rd_outstanding 0→1 after AR, back to 0 after rlast beat; err_underflow stays 0.
- MAX_RD=4, issue 6 ARs with downstream arready=1 and R stalled: exactly 4 accepted, axs_s0_arready=0 for the 5th. After one rlast, the 5th is accepted on the next cycle.
- AW and first W beat presented in the same cycle: axm_m0_wvalid=0 that cycle and 1 the next; wpend_cnt returns to 0 after wlast; wr_cnt holds 1 until the B handshake.
- Same-cycle AR handshake and rlast handshake with rd_cnt=2: rd_cnt stays 2.
- With 3 reads outstanding, raise drain_req: no new AR/AW accepted; drain_done=1 one cycle after the 3rd rlast; deasserts one cycle after drain_req drops.
- Inject B response with wr_cnt=0: bvalid forwarded, wr_cnt stays 0, err_underflow=1 until reset_n low.
